// File: rtl/dac_serial_tx.sv
// Dual-channel SPI-style DAC serialiser: one 16-bit frame per channel, MSB first, shared SCLK/SYNC_N.
// Optional build macro DAC_TX_PD_EN adds PD_MODE, which is carried in frame bits 13:12.
//   state | meaning
//   IDLE  | READY high, waiting for START
//   LEAD  | SYNC_N low, bit 15 on DIN, waiting for first SCLK fall
//   SHIFT | toggling SCLK, advancing DIN on each rising SCLK
//   GAP   | SYNC_N high for one half-period before READY/DONE
module dac_serial_tx #(
  parameter int CLK_DIV = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
`ifdef DAC_TX_PD_EN
  input  logic [1:0]  PD_MODE,
`endif
  input  logic [11:0] DATA_A,
  input  logic [11:0] DATA_B,
  input  logic        START,
  output logic        READY,
  output logic        DONE,
  output logic        SCLK,
  output logic        SYNC_N,
  output logic        DIN_A,
  output logic        DIN_B
);

  typedef enum logic [1:0] {IDLE, LEAD, SHIFT, GAP} state_t;

  localparam logic [7:0] HALF_LAST = 8'(CLK_DIV - 1);

  state_t      state, state_nxt;
  logic [7:0]  hcnt, hcnt_nxt;
  logic [4:0]  bit_cnt, bit_cnt_nxt;
  logic [15:0] sh_a, sh_a_nxt, sh_b, sh_b_nxt;
  logic        ready_nxt, done_nxt, sclk_nxt, sync_n_nxt;
  logic        tc, last_bit;
  logic [1:0]  pd_bits;
  logic [15:0] frame_a, frame_b;

`ifdef DAC_TX_PD_EN
  assign pd_bits = PD_MODE;
`else
  assign pd_bits = 2'b00;
`endif

  assign frame_a  = {2'b00, pd_bits, DATA_A};
  assign frame_b  = {2'b00, pd_bits, DATA_B};
  assign tc       = (hcnt == HALF_LAST);
  assign last_bit = (bit_cnt == 5'd15);
  assign DIN_A    = sh_a[15];
  assign DIN_B    = sh_b[15];

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state   <= IDLE;
      hcnt    <= '0;
      bit_cnt <= '0;
      sh_a    <= '0;
      sh_b    <= '0;
      READY   <= 1'b1;
      DONE    <= 1'b0;
      SCLK    <= 1'b1;
      SYNC_N  <= 1'b1;
    end else begin
      state   <= state_nxt;
      hcnt    <= hcnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      sh_a    <= sh_a_nxt;
      sh_b    <= sh_b_nxt;
      READY   <= ready_nxt;
      DONE    <= done_nxt;
      SCLK    <= sclk_nxt;
      SYNC_N  <= sync_n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (START) state_nxt = LEAD;
      LEAD:    if (tc) state_nxt = SHIFT;
      SHIFT:   if (tc && !SCLK && last_bit) state_nxt = GAP;
      GAP:     if (tc) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of every registered output; the half-period counter free-runs outside IDLE.
  always_comb begin
    hcnt_nxt    = (state == IDLE || tc) ? 8'd0 : hcnt + 8'd1;
    bit_cnt_nxt = bit_cnt;
    sh_a_nxt    = sh_a;
    sh_b_nxt    = sh_b;
    ready_nxt   = READY;
    done_nxt    = 1'b0;
    sclk_nxt    = SCLK;
    sync_n_nxt  = SYNC_N;
    case (state)
      IDLE: begin
        if (START) begin
          ready_nxt   = 1'b0;
          sync_n_nxt  = 1'b0;
          sclk_nxt    = 1'b1;
          bit_cnt_nxt = 5'd0;
          sh_a_nxt    = frame_a;
          sh_b_nxt    = frame_b;
        end
      end
      LEAD: begin
        if (tc) begin
          sclk_nxt    = 1'b0;
          bit_cnt_nxt = 5'd0;
        end
      end
      SHIFT: begin
        if (tc) begin
          sclk_nxt = ~SCLK;
          if (!SCLK) begin
            if (last_bit) begin
              sync_n_nxt = 1'b1;
              sh_a_nxt   = '0;
              sh_b_nxt   = '0;
            end else begin
              sh_a_nxt    = {sh_a[14:0], 1'b0};
              sh_b_nxt    = {sh_b[14:0], 1'b0};
              bit_cnt_nxt = bit_cnt + 5'd1;
            end
          end
        end
      end
      GAP: begin
        if (tc) begin
          ready_nxt = 1'b1;
          done_nxt  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dac_serial_tx.sv
// Bench for dac_serial_tx: two instances (CLK_DIV=4 and CLK_DIV=1) checked every cycle against
// a frame-timing model, plus captured-word tables and multi-cycle corner sequences.
module tb_dac_serial_tx;

  logic        clk;
  logic        rst_s   [2];
  logic        start_s [2];
  logic [11:0] da_s    [2];
  logic [11:0] db_s    [2];
  logic        ready_s [2];
  logic        done_s  [2];
  logic        sclk_s  [2];
  logic        sync_s  [2];
  logic        dina_s  [2];
  logic        dinb_s  [2];

  dac_serial_tx #(.CLK_DIV(4)) u_dut4 (
    .CLK(clk), .RESET_N(rst_s[0]), .DATA_A(da_s[0]), .DATA_B(db_s[0]), .START(start_s[0]),
    .READY(ready_s[0]), .DONE(done_s[0]), .SCLK(sclk_s[0]), .SYNC_N(sync_s[0]),
    .DIN_A(dina_s[0]), .DIN_B(dinb_s[0])
  );

  dac_serial_tx #(.CLK_DIV(1)) u_dut1 (
    .CLK(clk), .RESET_N(rst_s[1]), .DATA_A(da_s[1]), .DATA_B(db_s[1]), .START(start_s[1]),
    .READY(ready_s[1]), .DONE(done_s[1]), .SCLK(sclk_s[1]), .SYNC_N(sync_s[1]),
    .DIN_A(dina_s[1]), .DIN_B(dinb_s[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // Model: ph = cycles since acceptance (1..1+33H), -1 when idle with no DONE pending.
  int          ph [2];
  logic [15:0] wa [2];
  logic [15:0] wb [2];

  // Monitor: words sampled on SCLK falls, restarted on each SYNC_N fall.
  logic [15:0] cap_a [2], cap_b [2], last_a [2], last_b [2];
  int          falls [2], last_falls [2], done_cnt [2], last_sf [2], prev_sf [2];
  logic        prev_sclk [2], prev_sync [2];

  typedef struct {
    logic [11:0] a;
    logic [11:0] b;
    logic [15:0] want_a;
    logic [15:0] want_b;
  } vec_t;
  vec_t tbl [4];

  function automatic int h_of(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  // {READY, DONE, SCLK, SYNC_N, DIN_A, DIN_B} for a given point in the frame.
  function automatic logic [5:0] model_out(int p, int h, logic [15:0] fa, logic [15:0] fb);
    int q, idx;
    logic s;
    if (p < 0) return 6'b101100;
    if (p == 1 + 33*h) return 6'b111100;
    if (p < 1 + 32*h) begin
      q   = p - 1;
      s   = ((q / h) % 2) == 0;
      idx = 15 - q / (2*h);
      return {1'b0, 1'b0, s, 1'b0, fa[idx], fb[idx]};
    end
    return 6'b001100;
  endfunction

  task automatic check(string name, int got, int want);
    n_vec++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      logic [5:0] obs, want;
      bit rdy;
      int h;
      h   = h_of(d);
      obs = {ready_s[d], done_s[d], sclk_s[d], sync_s[d], dina_s[d], dinb_s[d]};
      if (chk_en) begin
        want = model_out(ph[d], h, wa[d], wb[d]);
        n_vec++;
        if (obs !== want) begin
          n_err++;
          $display("FAIL model dut%0d cyc %0d: got %b want %b (ready,done,sclk,sync_n,din_a,din_b)",
                   d, cyc, obs, want);
        end
      end
      if (prev_sync[d] && !sync_s[d]) begin
        cap_a[d] = '0; cap_b[d] = '0; falls[d] = 0;
        prev_sf[d] = last_sf[d]; last_sf[d] = cyc;
      end
      if (prev_sclk[d] && !sclk_s[d]) begin
        cap_a[d] = {cap_a[d][14:0], dina_s[d]};
        cap_b[d] = {cap_b[d][14:0], dinb_s[d]};
        falls[d]++;
      end
      if (done_s[d] === 1'b1) begin
        done_cnt[d]++;
        last_a[d] = cap_a[d]; last_b[d] = cap_b[d]; last_falls[d] = falls[d];
      end
      prev_sclk[d] = sclk_s[d];
      prev_sync[d] = sync_s[d];
      rdy = (ph[d] < 0) || (ph[d] == 1 + 33*h);
      if (!rst_s[d]) ph[d] = -1;
      else if (rdy && start_s[d]) begin
        ph[d] = 1; wa[d] = {4'b0000, da_s[d]}; wb[d] = {4'b0000, db_s[d]};
      end else if (ph[d] >= 1 && ph[d] < 1 + 33*h) ph[d]++;
      else ph[d] = -1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(int d, int budget, string name);
    int c0, i;
    c0 = done_cnt[d];
    i  = 0;
    while (done_cnt[d] == c0 && i < budget) begin
      step();
      i++;
    end
    check(name, done_cnt[d] - c0, 1);
  endtask

  task automatic send(int d, logic [11:0] a, logic [11:0] b);
    da_s[d] = a; db_s[d] = b; start_s[d] = 1'b1;
    step();
    start_s[d] = 1'b0;
    wait_done(d, 200, "done_timeout");
  endtask

  initial begin
    int c0;
    tbl[0] = '{12'hA5C, 12'h3F0, 16'h0A5C, 16'h03F0};
    tbl[1] = '{12'h001, 12'h800, 16'h0001, 16'h0800};
    tbl[2] = '{12'hFFF, 12'h000, 16'h0FFF, 16'h0000};
    tbl[3] = '{12'h555, 12'hAAA, 16'h0555, 16'h0AAA};
    for (int d = 0; d < 2; d++) begin
      rst_s[d] = 1'b0; start_s[d] = 1'b0; da_s[d] = '0; db_s[d] = '0;
      ph[d] = -1; wa[d] = '0; wb[d] = '0;
      cap_a[d] = '0; cap_b[d] = '0; last_a[d] = '0; last_b[d] = '0;
      falls[d] = 0; last_falls[d] = 0; done_cnt[d] = 0; last_sf[d] = 0; prev_sf[d] = 0;
      prev_sclk[d] = 1'b1; prev_sync[d] = 1'b1;
    end

    repeat (3) step();
    chk_en = 1'b1;
    step();
    rst_s[0] = 1'b1; rst_s[1] = 1'b1;
    repeat (20) step();

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 4; i++) begin
        send(d, tbl[i].a, tbl[i].b);
        check($sformatf("tbl_a d%0d i%0d", d, i), last_a[d], tbl[i].want_a);
        check($sformatf("tbl_b d%0d i%0d", d, i), last_b[d], tbl[i].want_b);
        check($sformatf("tbl_falls d%0d i%0d", d, i), last_falls[d], 16);
      end
    end

    // Data change and a stray START while the frame is in flight.
    c0 = done_cnt[0];
    da_s[0] = 12'hA5C; db_s[0] = 12'h3F0; start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    repeat (9) step();
    da_s[0] = 12'hFFF;
    repeat (40) step();
    start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    wait_done(0, 200, "mid_done_timeout");
    repeat (20) step();
    check("mid_word_a", last_a[0], 16'h0A5C);
    check("mid_word_b", last_b[0], 16'h03F0);
    check("mid_done_count", done_cnt[0] - c0, 1);

    // START held high at H=1: second frame accepted on the DONE cycle.
    da_s[1] = 12'h001; db_s[1] = 12'h000; start_s[1] = 1'b1;
    step();
    da_s[1] = 12'h800; db_s[1] = 12'hFFF;
    wait_done(1, 60, "b2b_done1_timeout");
    check("b2b_first_a", last_a[1], 16'h0001);
    repeat (3) step();
    start_s[1] = 1'b0;
    wait_done(1, 60, "b2b_done2_timeout");
    check("b2b_second_a", last_a[1], 16'h0800);
    check("b2b_second_b", last_b[1], 16'h0FFF);
    check("b2b_spacing", last_sf[1] - prev_sf[1], 34);

    // Reset at cycle 60 of a frame.
    da_s[0] = 12'h123; db_s[0] = 12'h456; start_s[0] = 1'b1;
    step();
    start_s[0] = 1'b0;
    repeat (59) step();
    rst_s[0] = 1'b0;
    step();
    rst_s[0] = 1'b1;
    c0 = done_cnt[0];
    repeat (150) step();
    check("rst_no_done", done_cnt[0] - c0, 0);
    send(0, 12'h789, 12'hABC);
    check("rst_after_a", last_a[0], 16'h0789);
    check("rst_after_b", last_b[0], 16'h0ABC);

    // Random traffic with occasional resets.
    repeat (600) begin
      for (int d = 0; d < 2; d++) begin
        start_s[d] = ($urandom_range(0, 7) == 0);
        da_s[d]    = 12'($urandom);
        db_s[d]    = 12'($urandom);
        rst_s[d]   = ($urandom_range(0, 150) != 0);
      end
      step();
    end
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 1'b0; rst_s[d] = 1'b1;
    end
    repeat (150) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dac_serial_tx.md
Name: dac_serial_tx

Overview:
Serialises 12-bit samples from the waveform generators into a dual-channel SPI-style DAC (DAC121S101 class: two data lines sharing SCLK and SYNC). Sits between the per-channel waveform DATA outputs and the board DAC pins. Accepts one sample pair per START/READY handshake and emits one 16-bit frame per channel: 4 control bits, then 12 data bits, MSB first.

Parameters:
CLK_DIV, 4, SCLK half-period in CLK cycles; legal range 1..255.

Ports:
CLK  input  1  system clock; all logic on rising edge.
RESET_N  input  1  synchronous reset, active low.
DATA_A  input  12  channel A sample; captured on handshake.
DATA_B  input  12  channel B sample; captured on handshake.
START  input  1  request to send the current DATA_A/DATA_B.
READY  output  1  high when a START will be accepted.
DONE  output  1  one-cycle pulse when a frame completes.
SCLK  output  1  serial clock to the DAC; idles high.
SYNC_N  output  1  frame select, active low; idles high.
DIN_A  output  1  serial data, channel A.
DIN_B  output  1  serial data, channel B.

Behaviour:
- Reset (RESET_N=0 at a CLK edge): READY=1, DONE=0, SCLK=1, SYNC_N=1, DIN_A=DIN_B=0.
  - All counters clear and the FSM returns to IDLE.
  - Reset mid-frame aborts the frame; the next edge shows idle outputs. No DONE is issued.
- Frame word per channel: {4'b0000, DATA[11:0]}, shifted MSB first.
- States: IDLE -> LEAD -> SHIFT -> GAP -> IDLE.
- Handshake:
  - START is accepted at an edge where START=1 and READY=1. Call that edge cycle 0.
  - DATA_A and DATA_B are latched at cycle 0. Later input changes have no effect on the frame.
  - READY drops at cycle 1.
  - START while READY=0 is ignored, with no queuing.
- Timing, all outputs registered, with H = CLK_DIV:
  - Cycle 1: SYNC_N=0, SCLK=1, DIN = bit 15.
  - Cycle 1+H: first SCLK falling edge; the DAC samples bit 15.
  - The k-th falling edge (k=1..16) is at cycle 1+H+2(k-1)H.
  - SCLK rises H cycles after each fall.
  - At each rising edge (k=1..15) DIN advances to the next bit, so DIN is stable for H cycles before each falling edge.
  - The 16th fall is at cycle 1+31H.
  - At cycle 1+32H: SCLK=1 and SYNC_N=1 (GAP state). DIN returns to 0.
  - At cycle 1+33H: READY=1, DONE=1 for exactly one cycle, FSM in IDLE.
- Throughput:
  - Accept-to-accept minimum is 1+33H cycles.
  - START held high continuously re-accepts on the first READY=1 cycle, which is also the DONE cycle.
- DIN_A and DIN_B are bit-aligned and share SCLK/SYNC_N.
- Internal widths:
  - Half-period counter: 8 bits, counting 0..H-1 and wrapping.
  - Bit counter: 5 bits.
- For H=1, SCLK toggles every CLK cycle; the same formulas hold.

Optional Feature:
DAC_TX_PD_EN
- Defined:
  - Adds input PD_MODE [1:0], latched with the data at acceptance.
  - Frame becomes {2'b00, PD_MODE, DATA[11:0]}. PD_MODE goes to both channels.
  - 2'b00 = normal; other values select the DAC power-down modes.
- Undefined:
  - The port is absent and bits 13:12 are always 0.
  - Timing is identical in both builds.

Test Plan:
- Reset, then idle 20 cycles -> READY=1, SCLK=1, SYNC_N=1, DIN_A=DIN_B=0, DONE=0 throughout.
- H=4, START with DATA_A=12'hA5C, DATA_B=12'h3F0 -> SYNC_N low at cycle 1; 16 falling edges at 5,13,...,125.
  - Bits sampled on falls: A = 0000_1010_0101_1100, B = 0000_0011_1111_0000.
  - SYNC_N high at 129; READY and DONE at 133.
- Change DATA_A to 12'hFFF at cycle 10 and pulse START at cycle 50 mid-frame -> frame still carries 12'hA5C, the start is ignored, only one DONE.
- START held high, H=1, DATA_A=12'h001 then 12'h800 -> back-to-back frames 34 cycles apart; the second is accepted on the DONE cycle; LSB then MSB patterns are correct.
- RESET_N=0 at cycle 60 of a frame -> cycle 61 shows idle outputs and READY=1, no DONE; a following START sends a complete frame.
- With DAC_TX_PD_EN defined, PD_MODE=2'b11, DATA_A=12'h000 -> serial bits on DIN_A = 0011_0000_0000_0000.
